imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time program loader sitting directly upstream of the instruction memory and the single-cycle RISC-V core. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words sequentially into the instruction RAM write port. It holds the core in reset until a complete, checksum-verified program has been written.

Parameters:
WORDS, 64, instruction RAM depth in 32-bit words.
ADDR_W, 6, word-address width; must equal clog2(WORDS).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
in_data  input  8  incoming stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready at a rising edge.
reload  input  1  single-cycle request to restart loading; honoured only in DONE or ERROR.
imem_we  output  1  instruction RAM write enable.
imem_waddr  output  ADDR_W  instruction RAM word address.
imem_wdata  output  32  instruction word to write.
core_reset  output  1  active-high reset to the core and PC register; 1 while loading or in error.
done  output  1  program loaded and verified.
error  output  1  frame rejected (length or checksum).

Behaviour:
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian word count), then 4*N payload bytes (each word least-significant byte first), then one CHK byte.
- CHK equals the 8-bit modulo-256 sum of all payload bytes. Length bytes are excluded from the sum.
- States: LEN0 -> LEN1 -> DATA -> CHECK -> DONE, plus ERROR. Each transition below occurs on an accepted byte unless stated otherwise.
- LEN0: capture LEN_LO; go to LEN1.
- LEN1: capture LEN_HI.
  - N > WORDS: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA: shift each byte into the word assembler and add it to the running checksum. The 4th byte of a word completes that word.
  - On completion, in the next cycle: imem_we=1 for exactly one cycle, imem_waddr = word index, imem_wdata = assembled word. Write latency is 1 cycle after the 4th byte handshake.
  - The word index increments after each write.
  - After word N-1 completes, go to CHECK.
- CHECK: compare the accepted byte with the running sum.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE: core_reset=0, done=1, in_ready=0.
- ERROR: core_reset=1, error=1, in_ready=0.
- in_ready is a decode of state: 1 in LEN0, LEN1, DATA and CHECK; 0 in DONE and ERROR.
- Bytes offered while in_ready=0 are not consumed and are not counted.
- reload in DONE or ERROR: next state LEN0. This clears the word index, checksum, assembler, done and error, and sets core_reset=1.
- reload in any other state is ignored.
- reload together with in_valid in DONE: the byte is not accepted; only the state change occurs.
- Gaps: in_valid may drop at any point, including mid-word. State holds with no timeout.
- Reset values while reset=0: state LEN0, core_reset=1, imem_we=0, imem_waddr=0, imem_wdata=0, done=0, error=0, word index=0, checksum=0. in_ready=1 (decoded from LEN0).
- Reset asserted mid-frame: the partial frame is discarded, and RAM words already written remain in RAM. The next frame starts at LEN0.
- Checksum arithmetic wraps modulo 256. The word index never exceeds WORDS-1 because N is bounded in LEN1.
- core_reset changes only on state transitions. It is registered, with no combinational path from in_data.

Decomposition:
- Package loader_pkg holds:
  - the state enum loader_state_t (LEN0, LEN1, DATA, CHECK, DONE, ERROR);
  - the constant CHK_W=8;
  - the constant BYTES_PER_WORD=4.
- One sub-module, byte_packer:
  - shifts accepted bytes into a 32-bit little-endian word;
  - has a 2-bit byte counter;
  - pulses word_valid on the 4th byte;
  - is cleared by the loader on reload or reset.

Test Plan:
- Nominal load: send 02 00 13 01 50 00 93 01 C0 00 B8. Expect imem_we pulses with (addr 0, 0x00500113) then (addr 1, 0x00C00193). Expect done=1 and core_reset=0 one cycle after the B8 handshake.
- Bad checksum: same frame with final byte B9. Expect both writes to occur, then error=1, core_reset=1, in_ready=0, done=0.
- Length bound: send 41 00 (N=65, WORDS=64). Expect ERROR after the 2nd byte, no imem_we, and in_ready=0.
- Zero length plus reload: send 00 00 00 and expect done=1. Pulse reload with in_valid=1 and data AA. Expect AA not consumed, state LEN0, core_reset=1, done=0.
- Backpressure and gaps: nominal frame with in_valid toggled every other cycle and a 5-cycle gap between bytes 2 and 3 of word 0. Expect identical writes and done.
- Async reset mid-frame: drop reset after 5 payload bytes, asynchronously relative to clk. Expect outputs at reset values immediately. A fresh nominal frame after release must load correctly from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int CHK_W          = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte lands in bits [7:0].
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        // Word is presented combinationally so the completing byte is included.
        word       = {byte_data, shift_q[31:8]};
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (byte_valid) begin
            shift_d    = word;
            cnt_d      = cnt_q + 2'd1;
            word_valid = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes verified program words into instruction RAM
// and holds the core in reset until the whole frame has passed its checksum.
module imem_loader
    import loader_pkg::*;
#(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [CHK_W-1:0]  chk_q, chk_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        accept;
    logic        pack_valid;
    logic        pack_clear;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_full;
    logic        last_word;

    assign in_ready   = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CHECK);
    assign accept     = in_valid && in_ready;
    assign pack_valid = accept && (state_q == DATA);
    assign pack_clear = reload && ((state_q == DONE) || (state_q == ERROR));
    assign len_full   = {in_data, len_lo_q};
    assign last_word  = ({{(16 - ADDR_W){1'b0}}, word_idx_q} == (n_q - 16'd1));

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            LEN0: if (accept) begin
                len_lo_d = in_data;
                state_d  = LEN1;
            end
            LEN1: if (accept) begin
                n_d = len_full;
                if (len_full > 16'(WORDS))  state_d = ERROR;
                else if (len_full == 16'd0) state_d = CHECK;
                else                        state_d = DATA;
            end
            DATA: if (accept) begin
                chk_d = chk_q + in_data;
                // Registering the write here gives the one-cycle write latency.
                if (word_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = word_idx_q;
                    wdata_d    = word;
                    word_idx_d = word_idx_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
                    if (last_word) state_d = CHECK;
                end
            end
            CHECK: if (accept) begin
                state_d = (in_data == chk_q) ? DONE : ERROR;
            end
            DONE, ERROR: if (reload) begin
                state_d    = LEN0;
                word_idx_d = '0;
                chk_d      = '0;
            end
            default: state_d = LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LEN0;
            len_lo_q   <= 8'd0;
            n_q        <= 16'd0;
            word_idx_q <= '0;
            chk_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            chk_q      <= chk_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Status outputs decode the registered state only, so no in_data path reaches them.
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus hand-written
// sequences for gaps, backpressure and asynchronous reset.
`timescale 1ns/100ps
module tb_imem_loader;

    localparam int ADDR_W = 6;

    // Expected status flags: {in_ready, core_reset, done, error}
    localparam logic [3:0] F_LOAD = 4'b1100;
    localparam logic [3:0] F_DONE = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0101;

    logic              clk;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic              v;
        logic [7:0]        d;
        logic              rl;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [3:0]        flags;
    } vec_t;

    vec_t vecs[$];
    logic [37:0] wq[$];
    logic [7:0]  nominal[$];

    imem_loader #(.WORDS(64), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: a one-cycle imem_we pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_waddr, imem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check({tag, " in_ready"},   32'(in_ready),   32'(exp[3]));
        check({tag, " core_reset"}, 32'(core_reset), 32'(exp[2]));
        check({tag, " done"},       32'(done),       32'(exp[1]));
        check({tag, " error"},      32'(error),      32'(exp[0]));
    endtask

    // Offer one byte until accepted (bounded), then idle one cycle.
    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            got = in_ready;
            @(posedge clk);
            #1;
        end
        check("send_byte accepted", 32'(got), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [7:0] d, input logic rl, input logic we,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [3:0] f);
        vec_t r;
        r.v = v; r.d = d; r.rl = rl; r.we = we; r.addr = a; r.wd = wd; r.flags = f;
        vecs.push_back(r);
    endtask

    task automatic push_frame_body();
        push(1, 8'h02, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h13, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h01, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h50, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 1, 0, 32'h00500113, F_LOAD);
        push(1, 8'h93, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h01, 0, 0, 0, 0, F_LOAD);
        push(1, 8'hC0, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 1, 1, 32'h00C00193, F_LOAD);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        nominal  = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                     8'h93, 8'h01, 8'hC0, 8'h00, 8'hB8};

        // Nominal frame, then reload with a byte offered alongside
        push_frame_body();
        push(1, 8'hB8, 0, 0, 0, 0, F_DONE);
        push(0, 8'h00, 0, 0, 0, 0, F_DONE);
        push(1, 8'hAA, 1, 0, 0, 0, F_LOAD);
        // Bad checksum
        push_frame_body();
        push(1, 8'hB9, 0, 0, 0, 0, F_ERR);
        push(1, 8'h55, 0, 0, 0, 0, F_ERR);
        push(0, 8'h00, 1, 0, 0, 0, F_LOAD);
        // Length bound: N=65
        push(1, 8'h41, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_ERR);
        push(1, 8'h12, 0, 0, 0, 0, F_ERR);
        push(0, 8'h00, 1, 0, 0, 0, F_LOAD);
        // Zero length, then reload+AA, then zero length again
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_DONE);
        push(1, 8'hAA, 1, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_DONE);
        push(0, 8'h00, 1, 0, 0, 0, F_LOAD);
        // N=64 accepted; reload mid-DATA is ignored and its byte is consumed
        push(1, 8'h40, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h00, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h11, 1, 0, 0, 0, F_LOAD);
        push(1, 8'h22, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h33, 0, 0, 0, 0, F_LOAD);
        push(1, 8'h44, 0, 1, 0, 32'h44332211, F_LOAD);

        // Reset values
        #2;
        check_flags("reset", F_LOAD);
        check("reset imem_we", 32'(imem_we), 32'd0);
        check("reset imem_waddr", 32'(imem_waddr), 32'd0);
        check("reset imem_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            reload   = vecs[i].rl;
            @(posedge clk);
            #1;
            reload = 1'b0;
            check_flags(tag, vecs[i].flags);
            check({tag, " imem_we"}, 32'(imem_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check({tag, " imem_waddr"}, 32'(imem_waddr), 32'(vecs[i].addr));
                check({tag, " imem_wdata"}, imem_wdata, vecs[i].wd);
            end
            $display("vec%0d: v=%0b d=%h rl=%0b -> we=%0b addr=%0d wdata=%h rdy=%0b cr=%0b done=%0b err=%0b",
                     i, vecs[i].v, vecs[i].d, vecs[i].rl, imem_we, imem_waddr, imem_wdata,
                     in_ready, core_reset, done, error);
        end
        in_valid = 1'b0;

        // Leave the stuck N=64 frame via reset
        #3 reset = 1'b0;
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();

        // Gapped, toggled nominal frame with a 5-cycle hole inside word 0
        foreach (nominal[i]) begin
            send_byte(nominal[i]);
            if (i == 3) repeat (5) @(posedge clk);
            #0;
        end
        #1;
        check_flags("gap end", F_DONE);
        check("gap writes", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("gap write0", 32'(wq[0][37:32]), 32'd0);
            check("gap data0", wq[0][31:0], 32'h00500113);
            check("gap write1", 32'(wq[1][37:32]), 32'd1);
            check("gap data1", wq[1][31:0], 32'h00C00193);
        end
        $display("gap frame: writes=%0d done=%0b core_reset=%0b", wq.size(), done, core_reset);

        // Asynchronous reset after 5 payload bytes
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(nominal[i]);
        check("pre-reset wdata", imem_wdata, 32'h00500113);
        #2.3 reset = 1'b0;
        #0.5;
        check_flags("async reset", F_LOAD);
        check("async imem_we", 32'(imem_we), 32'd0);
        check("async imem_waddr", 32'(imem_waddr), 32'd0);
        check("async imem_wdata", imem_wdata, 32'd0);
        $display("async reset: rdy=%0b cr=%0b we=%0b wdata=%h", in_ready, core_reset, imem_we, imem_wdata);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        foreach (nominal[i]) send_byte(nominal[i]);
        check_flags("post-reset end", F_DONE);
        check("post-reset writes", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("post-reset addr0", 32'(wq[0][37:32]), 32'd0);
            check("post-reset data0", wq[0][31:0], 32'h00500113);
            check("post-reset addr1", 32'(wq[1][37:32]), 32'd1);
            check("post-reset data1", wq[1][31:0], 32'h00C00193);
        end
        $display("post-reset frame: writes=%0d done=%0b", wq.size(), done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
